// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the set-associative data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WB    = 2'd1,
        ST_ALLOC = 2'd2
    } state_e;

    // Byte-offset width inside a line.
    function automatic int off_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    // Set-index width.
    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    // Tag width: whatever the offset and index leave over.
    function automatic int tag_w(input int addr_w, input int sets, input int line_w);
        return addr_w - idx_w(sets) - off_w(line_w);
    endfunction

    // Way-number width; a direct-mapped cache still carries one bit.
    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Extract 'width' bits of an address starting at bit 'lsb'.
    function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb,
                                               input int width);
        return (addr >> lsb) & ((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/dcache_lru.sv
// True-LRU age tracking: one age per way per set, 0 = most recent.
module dcache_lru
    import dcache_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int WAYS  = 2,
    parameter int IDX_W = idx_w(SETS),
    parameter int WAY_W = way_w(WAYS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             acc_en_i,
    input  logic [IDX_W-1:0] acc_set_i,
    input  logic [WAY_W-1:0] acc_way_i,
    input  logic [IDX_W-1:0] vic_set_i,
    output logic [WAY_W-1:0] vic_way_o
);

    localparam int AGE_W = WAY_W;

    logic [AGE_W-1:0] age_q    [SETS][WAYS];
    logic [AGE_W-1:0] age_d    [SETS][WAYS];
    logic [AGE_W-1:0] age_init [SETS][WAYS];
    logic [AGE_W-1:0] acc_age;

    // Reset image: way w starts with age w, so way WAYS-1 is the first victim.
    always_comb begin
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                age_init[s][w] = AGE_W'(w);
            end
        end
    end

    // Access update: younger ways age by one, the accessed way becomes youngest.
    always_comb begin
        age_d   = age_q;
        acc_age = age_q[acc_set_i][acc_way_i];
        if (acc_en_i) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[acc_set_i][w] < acc_age) begin
                    age_d[acc_set_i][w] = age_q[acc_set_i][w] + 1'b1;
                end
            end
            age_d[acc_set_i][acc_way_i] = '0;
        end
    end

    // Victim is the way holding the oldest age in the requested set.
    always_comb begin
        vic_way_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[vic_set_i][w] == AGE_W'(WAYS - 1)) begin
                vic_way_o = WAY_W'(w);
            end
        end
    end

    // Age register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            age_q <= age_init;
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/dcache_sa_ctrl.sv
// N-way set-associative write-back / write-allocate data cache with true-LRU.
// Handshake: mem_enable_o/mem_write_o/mem_addr_o/mem_data_o form a request held
// stable until the memory returns a one-cycle mem_ack_i; the CPU side is frozen
// by p1_stall_o and simply re-presents its access, which then hits.
module dcache_sa_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 16,
    parameter int WAYS   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [WORD_W-1:0] p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [WORD_W-1:0] p1_data_o,
    output logic              p1_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [1:0]        dbg_state_o
);

    localparam int OFF_W  = off_w(LINE_W);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_W);
    localparam int WAY_W  = way_w(WAYS);
    localparam int BSEL_W = $clog2(WORD_W / 8);
    localparam int WSEL_W = $clog2(LINE_W / WORD_W);

    // Array state
    logic              valid_q [SETS][WAYS];
    logic              valid_d [SETS][WAYS];
    logic              dirty_q [SETS][WAYS];
    logic              dirty_d [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [TAG_W-1:0]  tag_d   [SETS][WAYS];
    logic [LINE_W-1:0] line_q  [SETS][WAYS];
    logic [LINE_W-1:0] line_d  [SETS][WAYS];

    // Control state
    state_e            state_q, state_d;
    logic [TAG_W-1:0]  lat_tag_q, lat_tag_d;
    logic [IDX_W-1:0]  lat_idx_q, lat_idx_d;
    logic [WAY_W-1:0]  vic_way_q, vic_way_d;
    logic              mem_enable_q, mem_enable_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_data_q, mem_data_d;

    // Request decode and lookup
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WSEL_W-1:0] req_wsel;
    logic              req, hit, hit_any, inv_any, refill_done;
    logic [WAY_W-1:0]  hit_way, inv_way, lru_vic, miss_vic;
    logic              lru_en;
    logic [IDX_W-1:0]  lru_set;
    logic [WAY_W-1:0]  lru_way;

    assign req_tag  = TAG_W'(addr_field(64'(p1_addr_i), OFF_W + IDX_W, TAG_W));
    assign req_idx  = IDX_W'(addr_field(64'(p1_addr_i), OFF_W, IDX_W));
    assign req_wsel = WSEL_W'(addr_field(64'(p1_addr_i), BSEL_W, WSEL_W));
    assign req      = p1_MemRead_i | p1_MemWrite_i;

    // Tag compare and lowest-index invalid way in the addressed set.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[req_idx][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    assign hit      = req && hit_any && (state_q == ST_IDLE);
    assign miss_vic = inv_any ? inv_way : lru_vic;

    // Hits and refills both count as accesses for replacement.
    assign lru_en  = hit | refill_done;
    assign lru_set = hit ? req_idx : lat_idx_q;
    assign lru_way = hit ? hit_way : vic_way_q;

    dcache_lru #(
        .SETS  (SETS),
        .WAYS  (WAYS),
        .IDX_W (IDX_W),
        .WAY_W (WAY_W)
    ) u_lru (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .acc_en_i  (lru_en),
        .acc_set_i (lru_set),
        .acc_way_i (lru_way),
        .vic_set_i (req_idx),
        .vic_way_o (lru_vic)
    );

    // Zero-latency load data on a hit; zero otherwise.
    always_comb begin
        p1_data_o = '0;
        if (hit) begin
            p1_data_o = line_q[req_idx][hit_way][int'(req_wsel)*WORD_W +: WORD_W];
        end
    end

    assign p1_stall_o   = (req && !hit) || (state_q != ST_IDLE);
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign dbg_state_o  = state_q;

    // Next-state: store hits, miss dispatch, write-back and refill sequencing.
    // The stalled pipeline re-presents the access, so only the address is latched.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        tag_d        = tag_q;
        line_d       = line_q;
        lat_tag_d    = lat_tag_q;
        lat_idx_d    = lat_idx_q;
        vic_way_d    = vic_way_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        refill_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    if (p1_MemWrite_i) begin
                        line_d[req_idx][hit_way][int'(req_wsel)*WORD_W +: WORD_W] = p1_data_i;
                        dirty_d[req_idx][hit_way] = 1'b1;
                    end
                end else if (req) begin
                    lat_tag_d    = req_tag;
                    lat_idx_d    = req_idx;
                    vic_way_d    = miss_vic;
                    mem_enable_d = 1'b1;
                    if (valid_q[req_idx][miss_vic] && dirty_q[req_idx][miss_vic]) begin
                        state_d     = ST_WB;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {tag_q[req_idx][miss_vic], req_idx, OFF_W'(0)};
                        mem_data_d  = line_q[req_idx][miss_vic];
                    end else begin
                        state_d     = ST_ALLOC;
                        mem_write_d = 1'b0;
                        mem_addr_d  = {req_tag, req_idx, OFF_W'(0)};
                        mem_data_d  = '0;
                    end
                end
            end
            ST_WB: begin
                if (mem_ack_i) begin
                    state_d     = ST_ALLOC;
                    mem_write_d = 1'b0;
                    mem_addr_d  = {lat_tag_q, lat_idx_q, OFF_W'(0)};
                    mem_data_d  = '0;
                end
            end
            ST_ALLOC: begin
                if (mem_ack_i) begin
                    state_d                      = ST_IDLE;
                    line_d[lat_idx_q][vic_way_q]  = mem_data_i;
                    tag_d[lat_idx_q][vic_way_q]   = lat_tag_q;
                    valid_d[lat_idx_q][vic_way_q] = 1'b1;
                    dirty_d[lat_idx_q][vic_way_q] = 1'b0;
                    refill_done                  = 1'b1;
                    mem_enable_d                 = 1'b0;
                    mem_write_d                  = 1'b0;
                    mem_addr_d                   = '0;
                    mem_data_d                   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers; reset also aborts any memory request in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            valid_q      <= '{default: 1'b0};
            dirty_q      <= '{default: 1'b0};
            lat_tag_q    <= '0;
            lat_idx_q    <= '0;
            vic_way_q    <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            lat_tag_q    <= lat_tag_d;
            lat_idx_q    <= lat_idx_d;
            vic_way_q    <= vic_way_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    // Tag and data storage; contents are qualified by valid, so no reset.
    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        line_q <= line_d;
    end

endmodule

// File: tb/tb_dcache_sa_ctrl.sv
// Bench for dcache_sa_ctrl: directed scenarios followed by random traffic,
// checked against a CPU-view memory plus an MRU-ordered list of cached lines.
module tb_dcache_sa_ctrl;
    import dcache_pkg::*;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam int LINE_W = 256;
    localparam int SETS   = 16;
    localparam int WAYS   = 2;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] p1_addr  = '0;
    logic [WORD_W-1:0] p1_wdata = '0;
    logic              p1_rd    = 1'b0;
    logic              p1_wr    = 1'b0;
    logic [WORD_W-1:0] p1_data_o;
    logic              p1_stall_o;
    logic [LINE_W-1:0] mem_rdata = '0;
    logic              mem_ack   = 1'b0;
    logic [LINE_W-1:0] mem_data_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [1:0]        dbg_state;

    dcache_sa_ctrl #(
        .ADDR_W (ADDR_W), .WORD_W (WORD_W), .LINE_W (LINE_W), .SETS (SETS), .WAYS (WAYS)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .p1_addr_i     (p1_addr),
        .p1_data_i     (p1_wdata),
        .p1_MemRead_i  (p1_rd),
        .p1_MemWrite_i (p1_wr),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .mem_data_i    (mem_rdata),
        .mem_ack_i     (mem_ack),
        .mem_data_o    (mem_data_o),
        .mem_addr_o    (mem_addr_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .dbg_state_o   (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Initial memory contents: an address hash per word.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Line memory model with configurable ack latency
    logic [LINE_W-1:0] backing [int];
    typedef struct {
        bit                wr;
        logic [31:0]       addr;
        logic [LINE_W-1:0] data;
    } txn_t;
    txn_t obs_q[$];
    txn_t cur;
    int   lat  = 4;
    bit   busy = 1'b0;
    int   cnt  = 0;

    function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] la);
        logic [LINE_W-1:0] l;
        if (backing.exists(int'(la >> 5))) return backing[int'(la >> 5)];
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word(la + 32'(i * 4));
        return l;
    endfunction

    // Ack arrives on the lat-th cycle a request is seen; the model keeps counting
    // through a DUT reset so a late ack can be delivered.
    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack = 1'b0;
            busy    = 1'b0;
        end
        if (busy) begin
            if (mem_enable_o) begin
                chk("mem_addr_stable", LINE_W'(mem_addr_o), LINE_W'(cur.addr));
                chk("mem_write_stable", LINE_W'(mem_write_o), LINE_W'(cur.wr));
            end
            cnt++;
        end else if (mem_enable_o) begin
            busy     = 1'b1;
            cnt      = 1;
            cur.wr   = mem_write_o;
            cur.addr = mem_addr_o;
            cur.data = mem_data_o;
            obs_q.push_back(cur);
        end
        if (busy && cnt == lat) begin
            if (cur.wr) backing[int'(cur.addr >> 5)] = cur.data;
            else mem_rdata = mem_line(cur.addr);
            mem_ack = 1'b1;
        end
    end

    // Reference: CPU-visible memory and cached lines, most recent first.
    logic [31:0] ref_mem [int];
    typedef struct {
        int unsigned set;
        logic [31:0] la;
        bit          dirty;
    } cl_t;
    cl_t cache_q[$];

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        if (ref_mem.exists(int'(a >> 2))) return ref_mem[int'(a >> 2)];
        return init_word(a & ~32'h3);
    endfunction

    task automatic predict(input logic [31:0] a, input bit st, output bit hit, output bit wb,
                           output logic [31:0] wb_la, output logic [LINE_W-1:0] wb_line);
        logic [31:0] la = a & ~32'h1F;
        int unsigned set = (a >> 5) % SETS;
        int idx = -1;
        int n = 0;
        int last = -1;
        cl_t e;
        hit = 1'b0; wb = 1'b0; wb_la = '0; wb_line = '0;
        foreach (cache_q[i]) if (cache_q[i].la == la) idx = i;
        if (idx >= 0) begin
            e = cache_q[idx];
            cache_q.delete(idx);
            hit = 1'b1;
        end else begin
            foreach (cache_q[i]) if (cache_q[i].set == set) begin n++; last = i; end
            if (n == WAYS) begin
                if (cache_q[last].dirty) begin
                    wb    = 1'b1;
                    wb_la = cache_q[last].la;
                    for (int w = 0; w < 8; w++) wb_line[w*32 +: 32] = ref_word(wb_la + 32'(w * 4));
                end
                cache_q.delete(last);
            end
            e.set = set; e.la = la; e.dirty = 1'b0;
        end
        if (st) e.dirty = 1'b1;
        cache_q.push_front(e);
    endtask

    // One CPU access, held until the stall drops, then all effects checked.
    task automatic access(input logic [31:0] a, input bit rd, input bit wr,
                          input logic [31:0] wd, input int l);
        bit hit, wb;
        logic [31:0] wb_la, exp_data;
        logic [LINE_W-1:0] wb_line;
        int cyc = 0;
        int exp_cyc, k;
        bit st = wr;
        lat = l;
        predict(a, st, hit, wb, wb_la, wb_line);
        exp_data = ref_word(a);
        if (st) ref_mem[int'(a >> 2)] = wd;
        exp_cyc = hit ? 0 : (wb ? 2 * l + 1 : l + 1);
        obs_q.delete();
        @(negedge clk);
        p1_addr = a; p1_wdata = wd; p1_rd = rd; p1_wr = wr;
        #1;
        while (p1_stall_o && cyc < 40) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("stall_cycles", LINE_W'(cyc), LINE_W'(exp_cyc));
        if (!st) chk("load_data", LINE_W'(p1_data_o), LINE_W'(exp_data));
        @(posedge clk);
        #1;
        p1_rd = 1'b0; p1_wr = 1'b0;
        chk("txn_count", LINE_W'(obs_q.size()), LINE_W'(wb ? 2 : (hit ? 0 : 1)));
        k = 0;
        if (wb && obs_q.size() > 0) begin
            chk("wb_is_write", LINE_W'(obs_q[0].wr), LINE_W'(1));
            chk("wb_addr", LINE_W'(obs_q[0].addr), LINE_W'(wb_la));
            chk("wb_data", obs_q[0].data, wb_line);
            k = 1;
        end
        if (!hit && obs_q.size() > k) begin
            chk("alloc_is_read", LINE_W'(obs_q[k].wr), LINE_W'(0));
            chk("alloc_addr", LINE_W'(obs_q[k].addr), LINE_W'(a & ~32'h1F));
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_enable"}, LINE_W'(mem_enable_o), LINE_W'(0));
        chk({tag, "_write"}, LINE_W'(mem_write_o), LINE_W'(0));
        chk({tag, "_addr"}, LINE_W'(mem_addr_o), LINE_W'(0));
        chk({tag, "_data"}, mem_data_o, LINE_W'(0));
        chk({tag, "_stall"}, LINE_W'(p1_stall_o), LINE_W'(0));
        chk({tag, "_p1data"}, LINE_W'(p1_data_o), LINE_W'(0));
        chk({tag, "_state"}, LINE_W'(dbg_state), LINE_W'(ST_IDLE));
    endtask

    initial begin
        int n;
        logic [31:0] a;
        int op;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk_quiet("in_reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_quiet("after_reset");

        // Cold load, latency 4
        access(32'h0000_0040, 1'b1, 1'b0, '0, 4);

        // Same-set loads: third evicts the LRU line, clean so no write-back
        access(32'h0000_0000, 1'b1, 1'b0, '0, 3);
        access(32'h0000_0200, 1'b1, 1'b0, '0, 3);
        access(32'h0000_0400, 1'b1, 1'b0, '0, 3);

        // Dirty line write-back
        access(32'h0000_0000, 1'b0, 1'b1, 32'hDEAD_BEEF, 2);
        access(32'h0000_0200, 1'b1, 1'b0, '0, 2);
        access(32'h0000_0400, 1'b1, 1'b0, '0, 5);
        access(32'h0000_0000, 1'b1, 1'b0, '0, 2);

        // LRU ordering: 0x200 becomes least recent and is the victim
        access(32'h0000_0200, 1'b1, 1'b0, '0, 3);
        access(32'h0000_0000, 1'b1, 1'b0, '0, 3);
        access(32'h0000_0400, 1'b1, 1'b0, '0, 3);
        access(32'h0000_0004, 1'b1, 1'b0, '0, 3);

        // Read and write together act as a store; dirty shows up on eviction
        access(32'h0000_0008, 1'b1, 1'b1, 32'h1234_5678, 2);
        access(32'h0000_0008, 1'b1, 1'b0, '0, 2);
        access(32'h0000_0600, 1'b1, 1'b0, '0, 2);
        access(32'h0000_0800, 1'b1, 1'b0, '0, 2);

        // Latency 1 and latency 10 refills of the same line
        access(32'h0000_0A0C, 1'b1, 1'b0, '0, 1);
        access(32'h0000_0E00, 1'b1, 1'b0, '0, 1);
        access(32'h0000_1000, 1'b1, 1'b0, '0, 1);
        access(32'h0000_0A0C, 1'b1, 1'b0, '0, 10);

        // Reset during ALLOC with the ack arriving afterwards
        obs_q.delete();
        lat = 8;
        @(negedge clk);
        p1_addr = 32'h0000_3040; p1_rd = 1'b1; p1_wr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_alloc_state", LINE_W'(dbg_state), LINE_W'(ST_ALLOC));
        chk("mid_alloc_enable", LINE_W'(mem_enable_o), LINE_W'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_enable", LINE_W'(mem_enable_o), LINE_W'(0));
        p1_rd = 1'b0;
        #1;
        chk_quiet("async_rst");
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("late_ack_delivered", LINE_W'(n < 20), LINE_W'(1));
        @(negedge clk);
        #1;
        chk_quiet("late_ack");
        cache_q.delete();
        ref_mem.delete();
        backing.delete();
        access(32'h0000_0040, 1'b1, 1'b0, '0, 3);

        // Random traffic over a few conflicting sets
        for (int i = 0; i < 200; i++) begin
            a  = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5)
               | (32'($urandom_range(0, 7)) << 2);
            op = $urandom_range(0, 3);
            access(a, op != 2, op >= 2, $urandom, $urandom_range(1, 10));
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                #1;
                chk("idle_stall", LINE_W'(p1_stall_o), LINE_W'(0));
                chk("idle_data", LINE_W'(p1_data_o), LINE_W'(0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
